mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the core's single unified memory port between the instruction-fetch requester (F stage) and the load/store requester (M stage). The memory side uses a request/grant/response handshake with one transaction outstanding. Data accesses have priority, and a starvation counter guarantees that fetch eventually wins. The block also generates the F- and M-stage stall signals consumed by the pipeline control.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits; range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o.
- if_addr_i  in  32  fetch word address.
- if_gnt_o  out  1  fetch request accepted by memory.
- if_rvalid_o  out  1  fetch response valid, one cycle.
- if_rdata_o  out  32  fetch data; 0 when if_rvalid_o=0.
- dm_req_i  in  1  data request; held with dm_addr_i/dm_we_i/dm_be_i/dm_wdata_i stable until dm_gnt_o.
- dm_we_i  in  1  1=store, 0=load.
- dm_be_i  in  4  byte enables.
- dm_addr_i  in  32  data address.
- dm_wdata_i  in  32  store data.
- dm_gnt_o  out  1  data request accepted.
- dm_rvalid_o  out  1  data response valid; pulses for stores too.
- dm_rdata_o  out  32  load data; 0 when dm_rvalid_o=0.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  write enable; 0 for fetch.
- mem_be_o  out  4  byte enables; 4'hF for fetch.
- mem_addr_o  out  32  address.
- mem_wdata_o  out  32  write data; 0 for fetch.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  memory response, at least 1 cycle after grant.
- mem_rdata_i  in  32  memory read data.
- stall_f_o  out  1  F stage must hold.
- stall_m_o  out  1  M stage must hold.

## Operation

- FSM states are IDLE, REQ and RSP. Owner register values are FETCH and DATA. Starve counter is 4 bits and saturates at STARVE_LIMIT.
- Selection, evaluated in IDLE only:
  - Choose FETCH if if_req_i & (~dm_req_i | starve_cnt==STARVE_LIMIT).
  - Else choose DATA if dm_req_i.
- IDLE:
  - With any request, assert mem_req_o combinationally, muxing the selected requester's fields onto the mem_* outputs.
  - If mem_gnt_i, go to RSP. Otherwise latch the owner and go to REQ.
  - With no request, mem_req_o=0 and all mem_* outputs are 0.
- REQ:
  - Hold mem_req_o=1 with the latched owner's fields; selection is frozen and a newly arriving dm_req_i does not preempt fetch.
  - On mem_gnt_i, go to RSP.
- Grant routing: if_gnt_o = mem_gnt_i & mem_req_o & owner==FETCH. dm_gnt_o is analogous for DATA.
- RSP:
  - mem_req_o=0.
  - On mem_rvalid_i, pulse the owner's rvalid_o with rdata = mem_rdata_i, then go to IDLE.
  - No new request is issued in the response cycle.
- Starve counter, updated on each grant:
  - DATA grant with if_req_i=1: counter +1, saturating.
  - FETCH grant: counter reset to 0.
  - if_req_i=0 in IDLE: counter reset to 0.
- Stalls (combinational):
  - stall_f_o = (if_req_i | owner==FETCH in REQ/RSP) & ~if_rvalid_o.
  - stall_m_o is the same using dm_req_i, DATA and dm_rvalid_o.
- Reset, including assertion mid-transaction:
  - State goes to IDLE; owner and starve_cnt are cleared.
  - All outputs are 0: gnt, rvalid, rdata, mem_* and stalls. Stalls can only be 1 when an input request is high.
  - A mem_rvalid_i received in IDLE or REQ, including a late response to a pre-reset transaction, is ignored and produces no rvalid_o.

## Timing

- Minimum transaction is 2 cycles: request and grant in cycle 0, rvalid in cycle 1. The next request can issue in cycle 2, so peak throughput is one access per 2 cycles.
- mem_req_o, mem_* outputs and gnt_o are combinational from the IDLE inputs. rvalid_o and rdata_o are combinational from mem_rvalid_i and mem_rdata_i.
- There is no combinational path from mem_rvalid_i to mem_req_o.
- Under continuous dual requests with immediate grant, data wins STARVE_LIMIT times, then fetch wins once, and the pattern repeats.

## Test plan

- Fetch only: if_addr_i=0x100, mem_gnt_i=1 immediately, mem_rvalid_i in cycle 1 with 0xDEADBEEF -> if_gnt_o in cycle 0; if_rvalid_o=1 with if_rdata_o=0xDEADBEEF in cycle 1; mem_be_o=4'hF, mem_we_o=0; stall_f_o high in cycle 0 and low in cycle 1.
- Simultaneous requests, starve_cnt=0 -> DATA granted first and fetch stalls. Store dm_addr_i=0x2000, dm_wdata_i=0x12345678, dm_be_i=4'h3 -> mem outputs carry exactly those values; dm_rvalid_o pulses.
- Grant withheld 3 cycles after a fetch request, with dm_req_i rising in cycle 1 -> mem_addr_o stays at the fetch address; the fetch completes first and data follows.
- Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; counter saturates at 4 and never exceeds it.
- Reset asserted in RSP, then mem_rvalid_i pulses after reset release -> no if_rvalid_o or dm_rvalid_o; all outputs 0 during reset; state IDLE.
- Response latency of 5 cycles -> mem_req_o stays 0 throughout RSP, the stall of the owning stage stays high until the rvalid cycle, and the other requester waits.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, with data priority and a fetch anti-starvation counter
//   clk_i, rst_n_i            clock, async active-low reset
//   if_* / dm_*               fetch and data requester handshakes (req/gnt/rvalid/rdata)
//   mem_*                     unified memory port, one transaction outstanding
//   stall_f_o, stall_m_o      pipeline stalls for F and M stages
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_f_o,
  output logic        stall_m_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic {FETCH, DATA} owner_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t     state;
  owner_t     owner;
  owner_t     sel;
  logic [3:0] starve_cnt;
  logic       is_f;
  logic       grant;
  logic       rsp;
  // Selection is live only in IDLE; once a request is presented the owner is frozen.
  // mem_req is gated by reset so the port stays quiet while reset is held.
  always_comb begin
    sel         = (state == IDLE) ? ((if_req_i & (~dm_req_i | starve_cnt == LIMIT)) ? FETCH : DATA) : owner;
    is_f        = sel == FETCH;
    mem_req_o   = rst_n_i & ((state == IDLE) ? (if_req_i | dm_req_i) : (state == REQ));
    mem_we_o    = mem_req_o & ~is_f & dm_we_i;
    mem_be_o    = ~mem_req_o ? 4'h0 : is_f ? 4'hF : dm_be_i;
    mem_addr_o  = ~mem_req_o ? 32'h0 : is_f ? if_addr_i : dm_addr_i;
    mem_wdata_o = (mem_req_o & ~is_f) ? dm_wdata_i : 32'h0;
    grant       = mem_gnt_i & mem_req_o;
    if_gnt_o    = grant & is_f;
    dm_gnt_o    = grant & ~is_f;
    rsp         = (state == RSP) & mem_rvalid_i;
    if_rvalid_o = rsp & (owner == FETCH);
    dm_rvalid_o = rsp & (owner == DATA);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : 32'h0;
    stall_f_o   = (if_req_i | (state != IDLE & owner == FETCH)) & ~if_rvalid_o;
    stall_m_o   = (dm_req_i | (state != IDLE & owner == DATA)) & ~dm_rvalid_o;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      owner      <= FETCH;
      starve_cnt <= 4'h0;
    end else begin
      case (state)
        IDLE:    if (mem_req_o) begin
                   owner <= sel;
                   state <= mem_gnt_i ? RSP : REQ;
                 end
        REQ:     if (mem_gnt_i) state <= RSP;
        RSP:     if (mem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Counts data wins while fetch waits; any fetch win or idle fetch clears it.
      if (state == IDLE && !if_req_i)
        starve_cnt <= 4'h0;
      else if (grant)
        starve_cnt <= is_f ? 4'h0 : !if_req_i ? starve_cnt : (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'h1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;
  int          errors = 0;
  int          checks = 0;
  wire [139:0] outs = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt, dm_gnt,
                       if_rvalid, dm_rvalid, if_rdata, dm_rdata, stall_f, stall_m};

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .stall_f_o(stall_f), .stall_m_o(stall_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic w,
                       input logic [3:0] b, input logic [31:0] da, input logic [31:0] wd,
                       input logic g, input logic rv, input logic [31:0] rd);
    if_req = fr; if_addr = fa;
    dm_req = dr; dm_we = w; dm_be = b; dm_addr = da; dm_wdata = wd;
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (outs !== 140'h0) begin errors++; $display("FAIL reset_idle got %h exp 0", outs); end
    drive(0, 0, 1, 1, 4'hF, 32'h1234, 32'h5678, 1, 1, 32'hFFFF);
    #1;
    checks++;
    if ({mem_req, dm_gnt, if_gnt, dm_rvalid, mem_addr} !== 36'h0) begin
      errors++; $display("FAIL reset_req got %h exp 0", {mem_req, dm_gnt, if_gnt, dm_rvalid, mem_addr});
    end
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_only();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if ({if_gnt, dm_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall_f} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1}) begin
      errors++; $display("FAIL fetch_c0 got %h", {if_gnt, dm_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall_f});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    #1;
    checks++;
    if ({if_rvalid, if_rdata, dm_rvalid, stall_f, mem_req} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_c1 got %h", {if_rvalid, if_rdata, dm_rvalid, stall_f, mem_req});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    drive(1, 32'h200, 1, 1, 4'h3, 32'h2000, 32'h12345678, 1, 0, 0);
    #1;
    checks++;
    if ({dm_gnt, if_gnt, mem_we, mem_be, mem_addr, mem_wdata, stall_f} !== {1'b1, 1'b0, 1'b1, 4'h3, 32'h2000, 32'h12345678, 1'b1}) begin
      errors++; $display("FAIL sim_store got %h", {dm_gnt, if_gnt, mem_we, mem_be, mem_addr, mem_wdata, stall_f});
    end
    tick();
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555);
    #1;
    checks++;
    if ({dm_rvalid, dm_rdata, if_rvalid, stall_f, stall_m} !== {1'b1, 32'hAAAA5555, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sim_rsp got %h", {dm_rvalid, dm_rdata, if_rvalid, stall_f, stall_m});
    end
    tick();
    drive(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL sim_fetch got %h", {if_gnt, mem_addr});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h77}) begin
      errors++; $display("FAIL sim_fetch_rsp got %h", {if_rvalid, if_rdata});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_withheld();
    for (int c = 0; c < 4; c++) begin
      drive(1, 32'h300, c > 0, 0, 4'hF, 32'h4000, 0, c == 3, 0, 0);
      #1;
      checks++;
      if ({mem_req, mem_addr, if_gnt, dm_gnt} !== {1'b1, 32'h300, c == 3, 1'b0}) begin
        errors++; $display("FAIL withheld_c%0d got %h", c, {mem_req, mem_addr, if_gnt, dm_gnt});
      end
      tick();
    end
    drive(0, 0, 1, 0, 4'hF, 32'h4000, 0, 0, 1, 32'h33);
    #1;
    checks++;
    if ({if_rvalid, if_rdata, dm_rvalid, stall_m} !== {1'b1, 32'h33, 1'b0, 1'b1}) begin
      errors++; $display("FAIL withheld_rsp got %h", {if_rvalid, if_rdata, dm_rvalid, stall_m});
    end
    tick();
    drive(0, 0, 1, 0, 4'hF, 32'h4000, 0, 1, 0, 0);
    #1;
    checks++;
    if ({dm_gnt, if_gnt, mem_addr} !== {1'b1, 1'b0, 32'h4000}) begin
      errors++; $display("FAIL withheld_data got %h", {dm_gnt, if_gnt, mem_addr});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44);
    #1;
    checks++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h44}) begin
      errors++; $display("FAIL withheld_data_rsp got %h", {dm_rvalid, dm_rdata});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_back_to_back_starve();
    for (int t = 0; t < 10; t++) begin
      logic exp_f;
      exp_f = (t % (LIMIT + 1)) == LIMIT;
      drive(1, 32'h500 + t, 1, 0, 4'hF, 32'h6000 + t, 0, 1, 0, 0);
      #1;
      checks++;
      if ({if_gnt, dm_gnt} !== {exp_f, ~exp_f}) begin
        errors++; $display("FAIL starve_order_%0d got %b exp %b", t, {if_gnt, dm_gnt}, {exp_f, ~exp_f});
      end
      tick();
      drive(1, 32'h500 + t, 1, 0, 4'hF, 32'h6000 + t, 0, 0, 1, t);
      #1;
      checks++;
      if ({if_rvalid, dm_rvalid} !== {exp_f, ~exp_f}) begin
        errors++; $display("FAIL starve_rsp_%0d got %b exp %b", t, {if_rvalid, dm_rvalid}, {exp_f, ~exp_f});
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_in_rsp();
    drive(1, 32'h700, 1, 0, 4'hF, 32'h7000, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 140'h0) begin errors++; $display("FAIL rst_rsp_outs got %h exp 0", outs); end
    tick();
    rst_n = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555);
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_req} !== 67'h0) begin
      errors++; $display("FAIL rst_late_rsp got %h exp 0", {if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_req});
    end
    tick();
    drive(1, 32'h800, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h800}) begin
      errors++; $display("FAIL rst_idle got %h", {if_gnt, mem_addr});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_latency();
    drive(1, 32'h900, 1, 0, 4'hF, 32'h9000, 0, 1, 0, 0);
    #1;
    checks++;
    if ({dm_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL lat_gnt got %b exp 10", {dm_gnt, if_gnt}); end
    tick();
    for (int c = 1; c <= 5; c++) begin
      drive(1, 32'h900, 0, 0, 0, 0, 0, 1, c == 5, 32'h99);
      #1;
      checks++;
      if ({mem_req, if_gnt, stall_f, stall_m, dm_rvalid} !== {1'b0, 1'b0, 1'b1, c != 5, c == 5}) begin
        errors++; $display("FAIL lat_c%0d got %b", c, {mem_req, if_gnt, stall_f, stall_m, dm_rvalid});
      end
      tick();
    end
    drive(1, 32'h900, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h900}) begin errors++; $display("FAIL lat_fetch got %h", {if_gnt, mem_addr}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Model: busy = a granted access awaits its response, pend = requester presented but not yet granted.
  task automatic test_random();
    int starve = 0;
    int pend = -1;
    int rown = 0;
    int own, cur;
    bit busy = 0;
    bit f_acc = 0, d_acc = 0, idle;
    logic ereq, egnt, erv_f, erv_d;
    logic [139:0] exp_o;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (!if_req || f_acc) begin if_req = $urandom_range(0, 1) == 1; if_addr = $urandom; end
      if (!dm_req || d_acc) begin
        dm_req = $urandom_range(0, 1) == 1; dm_we = $urandom_range(0, 1) == 1;
        dm_be = 4'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_gnt = $urandom_range(0, 1) == 1;
      mem_rvalid = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
      #1;
      idle = !busy && pend < 0;
      own = pend >= 0 ? pend : ((if_req && (!dm_req || starve == LIMIT)) ? 0 : 1);
      ereq = !busy && (pend >= 0 || if_req || dm_req);
      egnt = ereq && mem_gnt;
      erv_f = busy && mem_rvalid && rown == 0;
      erv_d = busy && mem_rvalid && rown == 1;
      cur = busy ? rown : pend;
      exp_o = {ereq, ereq && own == 1 && dm_we,
               !ereq ? 4'h0 : own == 0 ? 4'hF : dm_be,
               !ereq ? 32'h0 : own == 0 ? if_addr : dm_addr,
               (ereq && own == 1) ? dm_wdata : 32'h0,
               egnt && own == 0, egnt && own == 1, erv_f, erv_d,
               erv_f ? mem_rdata : 32'h0, erv_d ? mem_rdata : 32'h0,
               (if_req || cur == 0) && !erv_f, (dm_req || cur == 1) && !erv_d};
      checks++;
      if (outs !== exp_o) begin
        errors++; $display("FAIL random_c%0d got %h exp %h", c, outs, exp_o);
      end
      f_acc = egnt && own == 0;
      d_acc = egnt && own == 1;
      if (idle && !if_req) starve = 0;
      else if (egnt) starve = own == 0 ? 0 : (if_req ? (starve + 1 > LIMIT ? LIMIT : starve + 1) : starve);
      if (busy && mem_rvalid) busy = 0;
      else if (egnt) begin busy = 1; rown = own; pend = -1; end
      else if (ereq) pend = own;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_withheld();
    test_back_to_back_starve();
    test_reset_in_rsp();
    test_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
